stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Mode controller and BCD time-keeping core for the stopwatch. It consumes the divider's 1 Hz/2 Hz enable pulses and ~4 Hz blink toggle, together with debounced one-cycle button pulses, and sequences RUN/PAUSED/ADJUST operation. It outputs the mm:ss digits and per-field blank masks to the seven-segment display driver.

## Interface
Parameters:
- MAX_MIN, 59, highest minute value before wrap (BCD-decoded, ≤ 99)
- MAX_SEC, 59, highest second value before wrap (≤ 59)

Ports:
- clk_100mhz  in  1  master clock
- rst_n  in  1  asynchronous reset, active-low
- en_1hz  in  1  one-cycle count enable, 1 Hz
- en_2hz  in  1  one-cycle adjust enable, 2 Hz
- clk_blink  in  1  ~4 Hz level toggle
- btn_pause  in  1  one-cycle pulse, run/pause toggle
- btn_clr  in  1  one-cycle pulse, clear time
- btn_lap  in  1  one-cycle pulse, lap hold toggle (ignored unless lap feature is compiled in)
- adj  in  1  level, adjust mode request
- sel  in  1  level, adjust field select: 0 = minutes, 1 = seconds
- disp  out  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD
- blank_min  out  1  blank minute digits
- blank_sec  out  1  blank second digits
- running  out  1  high in RUN
- lap_active  out  1  display frozen by lap hold
- wrap  out  1  one-cycle pulse on MAX_MIN:MAX_SEC → 00:00 in RUN

## Operation
- Reset values: state PAUSED, time 00:00, disp 0x0000, lap hold cleared. All other outputs are 0.
- The time is held as four BCD digits. Ones digits wrap 9→0 with a carry. Seconds wrap MAX_SEC→00 with a carry into minutes.
- States and transitions, evaluated every cycle in this priority order:
  - adj=1: ADJUST, entered from any state.
  - ADJUST with adj=0: PAUSED.
  - btn_pause in PAUSED: RUN.
  - btn_pause in RUN: PAUSED.
  - btn_pause in ADJUST: ignored.
- RUN:
  - Each en_1hz increments the time by 1 s.
  - At MAX_MIN:MAX_SEC the time goes to 00:00 and wrap pulses.
- PAUSED: the time holds; en_1hz and en_2hz are ignored.
- ADJUST:
  - Each en_2hz increments only the field chosen by sel.
  - A field wraps max→00 with no carry into the other field.
  - wrap stays 0.
- btn_clr:
  - Sets the time to 00:00 in any state; the state is unchanged.
  - It has priority over any same-cycle increment, so the result is 00:00.
- Same-cycle btn_pause and en_1hz in RUN: the tick is applied, then the state goes to PAUSED.
- Same-cycle adj rise and en_1hz in RUN: the tick is applied; the next cycle is ADJUST.
- blank_min = (state==ADJUST) & ~sel & clk_blink.
- blank_sec = (state==ADJUST) & sel & clk_blink.
- running = (state==RUN).

## Timing
- All outputs are registered. disp, wrap and running update one cycle after the qualifying input is sampled.
- blank_min and blank_sec are registered and lag clk_blink by exactly one cycle.
- Back-to-back en_1hz pulses on consecutive cycles each increment the time; no pulse is dropped.
- An asynchronous rst_n assertion mid-operation immediately forces all reset values. Release is synchronous to the next clk_100mhz edge.
- Input pulses are assumed to last exactly one cycle. A pulse held longer acts once per cycle; this case is not protected.

## Configuration
STOPWATCH_LAP_EN:
- When defined:
  - btn_lap in RUN captures the current time into a lap register and sets lap_active.
  - While lap_active is set, disp shows the lap register and counting continues internally.
  - btn_lap while lap_active is set, btn_clr, entering ADJUST, or reset clears lap_active. disp then returns to the live time on the next cycle.
  - btn_lap in PAUSED with lap_active clear is ignored.
- When undefined:
  - btn_lap is ignored.
  - lap_active is tied to 0.
  - disp always shows the live time.
  - No lap register is synthesized.

## Test plan
- Reset, then btn_pause, then 65 en_1hz pulses → running=1, disp=0x0105, wrap never asserted.
- Preload 59:58 in RUN, then 2 en_1hz pulses → disp=0x0000, wrap high for exactly one cycle on the second tick.
- adj=1, sel=1, 61 en_2hz pulses starting from 00:00 → disp=0x0001, minutes unchanged. blank_sec follows clk_blink delayed by 1 cycle; blank_min=0.
- In RUN, btn_clr coincident with en_1hz at 12:34 → disp=0x0000, state stays RUN. btn_pause coincident with en_1hz → time advances by 1 s and running=0.
- rst_n asserted low mid-count at 07:42 in RUN → disp=0x0000 and running=0 without waiting for a clock edge. After release, en_1hz is ignored until btn_pause.
- With STOPWATCH_LAP_EN: btn_lap at 00:10, then 5 en_1hz pulses → disp=0x0010 and lap_active=1. A second btn_lap → disp=0x0015 and lap_active=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mode controller and BCD mm:ss time-keeping core.
// Sequences PAUSED / RUN / ADJUST from debounced button pulses and the
// divider's enables, and drives registered digits and blank masks to the
// seven-segment driver.
// Optional feature macro: STOPWATCH_LAP_EN (lap hold register and lap_active).
module stopwatch_ctrl #(
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic        en_1hz,
    input  logic        en_2hz,
    input  logic        clk_blink,
    input  logic        btn_pause,
    input  logic        btn_clr,
    input  logic        btn_lap,
    input  logic        adj,
    input  logic        sel,
    output logic [15:0] disp,
    output logic        blank_min,
    output logic        blank_sec,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    // Field limits pre-encoded as two BCD digits so comparisons are direct.
    localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    localparam logic [7:0] MAX_SEC_BCD = {4'(MAX_SEC / 10), 4'(MAX_SEC % 10)};

    // Two-digit BCD increment; bit 8 flags the max->00 rollover.
    function automatic logic [8:0] bcd_inc(input logic [7:0] field,
                                           input logic [7:0] max_bcd);
        logic [8:0] r;
        if (field == max_bcd) begin
            r = {1'b1, 8'h00};
        end else if (field[3:0] == 4'd9) begin
            r = {1'b0, field[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, field[7:4], field[3:0] + 4'd1};
        end
        return r;
    endfunction

    state_t      state_reg, state_next;
    logic [7:0]  min_reg, min_next;
    logic [7:0]  sec_reg, sec_next;
    logic [8:0]  min_inc, sec_inc;
    logic        wrap_reg, wrap_next;
    logic [15:0] disp_reg, disp_next;
    logic        running_reg;
    logic        blank_min_reg, blank_sec_reg;

    assign min_inc = bcd_inc(min_reg, MAX_MIN_BCD);
    assign sec_inc = bcd_inc(sec_reg, MAX_SEC_BCD);

    // Mode state register.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_PAUSED;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next mode: adjust request dominates, leaving ADJUST always lands in
    // PAUSED, and the pause button only toggles between PAUSED and RUN.
    always_comb begin
        state_next = state_reg;
        if (adj) begin
            state_next = ST_ADJUST;
        end else if (state_reg == ST_ADJUST) begin
            state_next = ST_PAUSED;
        end else if (btn_pause) begin
            state_next = (state_reg == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
    end

    // Next time value: clear beats any increment; ticks act on the current
    // mode so a same-cycle mode change still lets the tick land.
    always_comb begin
        min_next  = min_reg;
        sec_next  = sec_reg;
        wrap_next = 1'b0;
        if (btn_clr) begin
            min_next = 8'h00;
            sec_next = 8'h00;
        end else if (state_reg == ST_RUN && en_1hz) begin
            sec_next = sec_inc[7:0];
            if (sec_inc[8]) begin
                min_next  = min_inc[7:0];
                wrap_next = min_inc[8];
            end
        end else if (state_reg == ST_ADJUST && en_2hz) begin
            if (sel) begin
                sec_next = sec_inc[7:0];
            end else begin
                min_next = min_inc[7:0];
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [15:0] lap_reg, lap_next;
    logic        lap_active_reg, lap_active_next;

    // Lap hold: cleared by clear, adjust or a second press; captured only
    // while running.
    always_comb begin
        lap_next        = lap_reg;
        lap_active_next = lap_active_reg;
        if (btn_clr || adj) begin
            lap_active_next = 1'b0;
        end else if (btn_lap && lap_active_reg) begin
            lap_active_next = 1'b0;
        end else if (btn_lap && state_reg == ST_RUN) begin
            lap_active_next = 1'b1;
            lap_next        = {min_reg, sec_reg};
        end
    end

    // Lap register and hold flag.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            lap_reg        <= 16'h0000;
            lap_active_reg <= 1'b0;
        end else begin
            lap_reg        <= lap_next;
            lap_active_reg <= lap_active_next;
        end
    end

    assign disp_next  = lap_active_next ? lap_next : {min_next, sec_next};
    assign lap_active = lap_active_reg;
`else
    // Lap button has no function in this build.
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign disp_next  = {min_next, sec_next};
    assign lap_active = 1'b0;
`endif

    // Time digits and all registered outputs.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            min_reg       <= 8'h00;
            sec_reg       <= 8'h00;
            wrap_reg      <= 1'b0;
            disp_reg      <= 16'h0000;
            running_reg   <= 1'b0;
            blank_min_reg <= 1'b0;
            blank_sec_reg <= 1'b0;
        end else begin
            min_reg       <= min_next;
            sec_reg       <= sec_next;
            wrap_reg      <= wrap_next;
            disp_reg      <= disp_next;
            running_reg   <= (state_next == ST_RUN);
            blank_min_reg <= (state_next == ST_ADJUST) & ~sel & clk_blink;
            blank_sec_reg <= (state_next == ST_ADJUST) & sel & clk_blink;
        end
    end

    assign disp      = disp_reg;
    assign wrap      = wrap_reg;
    assign running   = running_reg;
    assign blank_min = blank_min_reg;
    assign blank_sec = blank_sec_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed bench for stopwatch_ctrl with a seconds-count
// reference model checked every cycle plus hand-computed literal checks.
module tb_stopwatch_ctrl;

    localparam int MAX_MIN = 59;
    localparam int MAX_SEC = 59;
    localparam int M_PAUSED = 0;
    localparam int M_RUN    = 1;
    localparam int M_ADJ    = 2;

    logic        clk_100mhz = 1'b0;
    logic        rst_n      = 1'b0;
    logic        en_1hz     = 1'b0;
    logic        en_2hz     = 1'b0;
    logic        clk_blink  = 1'b0;
    logic        btn_pause  = 1'b0;
    logic        btn_clr    = 1'b0;
    logic        btn_lap    = 1'b0;
    logic        adj        = 1'b0;
    logic        sel        = 1'b0;
    logic [15:0] disp;
    logic        blank_min;
    logic        blank_sec;
    logic        running;
    logic        lap_active;
    logic        wrap;

    int n_tests  = 0;
    int n_fail   = 0;
    int wrap_cnt = 0;
    int bmin_cnt = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    stopwatch_ctrl #(.MAX_MIN(MAX_MIN), .MAX_SEC(MAX_SEC)) dut (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .en_1hz     (en_1hz),
        .en_2hz     (en_2hz),
        .clk_blink  (clk_blink),
        .btn_pause  (btn_pause),
        .btn_clr    (btn_clr),
        .btn_lap    (btn_lap),
        .adj        (adj),
        .sel        (sel),
        .disp       (disp),
        .blank_min  (blank_min),
        .blank_sec  (blank_sec),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap)
    );

    // Reference model: time as plain integer minutes/seconds.
    typedef struct packed {
        int mode;
        int mins;
        int secs;
        bit wrap;
        bit bmin;
        bit bsec;
        bit lap_on;
        int lap_min;
        int lap_sec;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t mdl_step(mdl_t m);
        mdl_t n;
        int   t;
        n = m;
        n.wrap = 1'b0;
        if (btn_clr) begin
            n.mins = 0;
            n.secs = 0;
        end else if (m.mode == M_RUN && en_1hz) begin
            t = m.mins * (MAX_SEC + 1) + m.secs + 1;
            if (t == (MAX_MIN + 1) * (MAX_SEC + 1)) begin
                t = 0;
                n.wrap = 1'b1;
            end
            n.mins = t / (MAX_SEC + 1);
            n.secs = t % (MAX_SEC + 1);
        end else if (m.mode == M_ADJ && en_2hz) begin
            if (sel) n.secs = (m.secs + 1) % (MAX_SEC + 1);
            else     n.mins = (m.mins + 1) % (MAX_MIN + 1);
        end
        if (adj)                  n.mode = M_ADJ;
        else if (m.mode == M_ADJ) n.mode = M_PAUSED;
        else if (btn_pause)       n.mode = (m.mode == M_RUN) ? M_PAUSED : M_RUN;
        n.bmin = (n.mode == M_ADJ) && !sel && clk_blink;
        n.bsec = (n.mode == M_ADJ) && sel && clk_blink;
`ifdef STOPWATCH_LAP_EN
        if (btn_clr || adj) begin
            n.lap_on = 1'b0;
        end else if (btn_lap && m.lap_on) begin
            n.lap_on = 1'b0;
        end else if (btn_lap && m.mode == M_RUN) begin
            n.lap_on  = 1'b1;
            n.lap_min = m.mins;
            n.lap_sec = m.secs;
        end
`endif
        return n;
    endfunction

    function automatic logic [15:0] bcd4(int mn, int sc);
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    // Model register, reset the same way as the design.
    always @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) mdl <= '0;
        else        mdl <= mdl_step(mdl);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [15:0] exp_disp;
        exp_disp = mdl.lap_on ? bcd4(mdl.lap_min, mdl.lap_sec) : bcd4(mdl.mins, mdl.secs);
        chk("mdl_disp", disp, exp_disp);
        chk("mdl_running", 16'(running), 16'(mdl.mode == M_RUN));
        chk("mdl_wrap", 16'(wrap), 16'(mdl.wrap));
        chk("mdl_blank_min", 16'(blank_min), 16'(mdl.bmin));
        chk("mdl_blank_sec", 16'(blank_sec), 16'(mdl.bsec));
        chk("mdl_lap_active", 16'(lap_active), 16'(mdl.lap_on));
    endtask

    // One clock; outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        compare_all();
        if (wrap) wrap_cnt++;
        if (blank_min) bmin_cnt++;
    endtask

    task automatic step(input bit p1, input bit p2, input bit pp, input bit pc, input bit pl);
        en_1hz = p1; en_2hz = p2; btn_pause = pp; btn_clr = pc; btn_lap = pl;
        cycle();
        en_1hz = 0; en_2hz = 0; btn_pause = 0; btn_clr = 0; btn_lap = 0;
        $display("[TB] 1hz=%0d 2hz=%0d pause=%0d clr=%0d lap=%0d adj=%0d sel=%0d -> disp=%h run=%0d wrap=%0d lap_active=%0d",
                 p1, p2, pp, pc, pl, adj, sel, disp, running, wrap, lap_active);
    endtask

    // Load mm:ss through ADJUST and return to PAUSED.
    task automatic preload(input int mn, input int sc);
        adj = 1'b1;
        sel = 1'b0;
        cycle();
        step(0, 0, 0, 1, 0);
        repeat (mn) step(0, 1, 0, 0, 0);
        sel = 1'b1;
        repeat (sc) step(0, 1, 0, 0, 0);
        adj = 1'b0;
        cycle();
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        compare_all();
        chk("rst_disp", disp, 16'h0000);
        chk("rst_running", 16'(running), 16'h0);
        chk("rst_wrap", 16'(wrap), 16'h0);
        chk("rst_lap_active", 16'(lap_active), 16'h0);
        rst_n = 1'b1;

        // Start, 65 back-to-back ticks
        step(0, 0, 1, 0, 0);
        wrap_cnt = 0;
        repeat (65) step(1, 0, 0, 0, 0);
        chk("t1_disp", disp, 16'h0105);
        chk("t1_running", 16'(running), 16'h1);
        chk("t1_wrap_cnt", 16'(wrap_cnt), 16'h0);

        // Wrap at 59:59
        preload(59, 58);
        step(0, 0, 1, 0, 0);
        chk("t2_preload", disp, 16'h5958);
        wrap_cnt = 0;
        step(1, 0, 0, 0, 0);
        chk("t2_disp_5959", disp, 16'h5959);
        chk("t2_wrap_early", 16'(wrap), 16'h0);
        step(1, 0, 0, 0, 0);
        chk("t2_disp_wrap", disp, 16'h0000);
        chk("t2_wrap_high", 16'(wrap), 16'h1);
        cycle();
        chk("t2_wrap_low", 16'(wrap), 16'h0);
        chk("t2_wrap_cnt", 16'(wrap_cnt), 16'h1);

        // Adjust seconds 61 times, blink varying
        adj = 1'b1;
        sel = 1'b1;
        cycle();
        step(0, 0, 0, 1, 0);
        bmin_cnt = 0;
        for (int i = 0; i < 61; i++) begin
            clk_blink = ((i / 3) % 2) == 1;
            step(0, 1, 0, 0, 0);
        end
        chk("t3_disp", disp, 16'h0001);
        chk("t3_bmin_cnt", 16'(bmin_cnt), 16'h0);
        clk_blink = 1'b1;
        cycle();
        chk("t3_bsec_on", 16'(blank_sec), 16'h1);
        clk_blink = 1'b0;
        chk("t3_bsec_lag", 16'(blank_sec), 16'h1);
        cycle();
        chk("t3_bsec_off", 16'(blank_sec), 16'h0);
        adj = 1'b0;
        cycle();
        chk("t3_leave_adj", 16'(running), 16'h0);

        // Clear and pause coinciding with ticks
        preload(12, 34);
        step(0, 0, 1, 0, 0);
        chk("t4_preload", disp, 16'h1234);
        step(1, 0, 0, 1, 0);
        chk("t4_clr_disp", disp, 16'h0000);
        chk("t4_clr_running", 16'(running), 16'h1);
        step(1, 0, 1, 0, 0);
        chk("t4_pause_disp", disp, 16'h0001);
        chk("t4_pause_running", 16'(running), 16'h0);

        // Asynchronous reset mid-count
        preload(7, 42);
        step(0, 0, 1, 0, 0);
        chk("t5_preload", disp, 16'h0742);
        chk("t5_running", 16'(running), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_disp", disp, 16'h0000);
        chk("t5_async_running", 16'(running), 16'h0);
        cycle();
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0);
        chk("t5_tick_ignored", disp, 16'h0000);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t5_restart_disp", disp, 16'h0001);
        chk("t5_restart_running", 16'(running), 16'h1);

`ifdef STOPWATCH_LAP_EN
        // Lap hold
        repeat (9) step(1, 0, 0, 0, 0);
        chk("t6_at_10", disp, 16'h0010);
        step(0, 0, 0, 0, 1);
        chk("t6_lap_set", 16'(lap_active), 16'h1);
        repeat (5) step(1, 0, 0, 0, 0);
        chk("t6_frozen_disp", disp, 16'h0010);
        chk("t6_frozen_active", 16'(lap_active), 16'h1);
        step(0, 0, 0, 0, 1);
        chk("t6_release_disp", disp, 16'h0015);
        chk("t6_release_active", 16'(lap_active), 16'h0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("t6_paused_lap_ignored", 16'(lap_active), 16'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
